// File: rtl/dma_burst_engine.sv
// Bus-side datapath of the DMA custom instruction: moves a block of words between the
// shared bus and port B of the DMA SSRAM as a series of bursts.
module dma_burst_engine #(
    parameter int MEM_AW = 9,
    parameter int BLK_W  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              readNotWrite,
    input  logic [31:0]       busStartAddress,
    input  logic [MEM_AW-1:0] memStartAddress,
    input  logic [BLK_W-1:0]  blockSize,
    input  logic [7:0]        burstSize,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [MEM_AW-1:0] memAddress,
    output logic              memWriteEnable,
    output logic [31:0]       memWriteData,
    input  logic [31:0]       memReadData,
    output logic              requestTransaction,
    input  logic              transactionGranted,
    output logic              beginTransactionOut,
    output logic [31:0]       addressDataOut,
    output logic [7:0]        burstSizeOut,
    output logic              readNotWriteOut,
    output logic              dataValidOut,
    output logic              endTransactionOut,
    input  logic [31:0]       addressDataIn,
    input  logic              dataValidIn,
    input  logic              endTransactionIn,
    input  logic              busErrorIn,
    input  logic              busyIn
);

    typedef enum logic [2:0] {
        IDLE, REQUEST, INIT, READ_DATA, WRITE_DATA, END_WRITE, FINISH
    } state_t;

    localparam int CW = (BLK_W > 9) ? BLK_W : 9;

    state_t            state, state_next;
    logic              dir;
    logic [31:0]       bus_addr;
    logic [MEM_AW-1:0] mem_addr;
    logic [BLK_W-1:0]  remaining;
    logic [7:0]        burst_m1;
    logic [8:0]        fetch_left;
    logic [8:0]        words_left;
    logic              error_q;

    // Prefetch buffer: SSRAM words read ahead so the bus sees one word per cycle.
    logic [31:0]       pf_data [2];
    logic [1:0]        pf_count;
    logic              pf_inflight;

    logic [CW-1:0]     burst_full, rem_ext, burst_words;
    logic              last_burst;
    logic              abort;
    logic              accept;
    logic              mem_we;
    logic              burst_done;
    logic              pf_avail, pf_pop, pf_issue;
    logic [1:0]        pf_occ;
    logic [31:0]       pf_head;

    assign burst_full  = CW'(burst_m1) + CW'(1);
    assign rem_ext     = CW'(remaining);
    assign burst_words = (burst_full < rem_ext) ? burst_full : rem_ext;
    assign last_burst  = (burst_words == rem_ext);

    assign accept     = (state == IDLE) && start;
    assign abort      = busErrorIn && (state != IDLE) && (state != FINISH);
    assign mem_we     = (state == READ_DATA) && dataValidIn && !busErrorIn;
    assign burst_done = ((state == READ_DATA) && endTransactionIn) || (state == END_WRITE);

    assign pf_avail = (pf_count != 2'd0) || pf_inflight;
    assign pf_head  = (pf_count != 2'd0) ? pf_data[0] : memReadData;
    assign pf_pop   = (state == WRITE_DATA) && pf_avail && !busyIn;
    assign pf_occ   = pf_count + {1'b0, pf_inflight};
    // A read is issued only if its data will have a slot when it returns next cycle.
    assign pf_issue = !dir && ((state == INIT) ||
                      ((state == WRITE_DATA) && (fetch_left != 9'd0) &&
                       ((pf_occ != 2'd2) || pf_pop)));

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (start) state_next = (blockSize != '0) ? REQUEST : FINISH;
            REQUEST:    if (transactionGranted) state_next = INIT;
            INIT:       state_next = dir ? READ_DATA : WRITE_DATA;
            READ_DATA:  if (endTransactionIn) state_next = last_burst ? FINISH : REQUEST;
            WRITE_DATA: if (pf_pop && (words_left == 9'd1)) state_next = END_WRITE;
            END_WRITE:  state_next = last_burst ? FINISH : REQUEST;
            FINISH:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (abort) state_next = FINISH;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            dir         <= 1'b0;
            bus_addr    <= '0;
            mem_addr    <= '0;
            remaining   <= '0;
            burst_m1    <= '0;
            fetch_left  <= '0;
            words_left  <= '0;
            error_q     <= 1'b0;
            pf_count    <= '0;
            pf_inflight <= 1'b0;
            pf_data[0]  <= '0;
            pf_data[1]  <= '0;
        end else begin
            state <= state_next;

            if (accept) error_q <= 1'b0;
            else if (abort) error_q <= 1'b1;

            if (accept) begin
                dir       <= readNotWrite;
                bus_addr  <= busStartAddress;
                remaining <= blockSize;
                burst_m1  <= burstSize;
            end else if (burst_done) begin
                remaining <= remaining - BLK_W'(burst_words);
                bus_addr  <= bus_addr + (32'(burst_words) << 2);
            end

            if (accept) mem_addr <= memStartAddress;
            else if (mem_we || pf_issue) mem_addr <= mem_addr + 1'b1;

            if (state == INIT) begin
                fetch_left <= 9'(burst_words) - 9'd1;
                words_left <= 9'(burst_words);
            end else begin
                if (pf_issue) fetch_left <= fetch_left - 9'd1;
                if (pf_pop) words_left <= words_left - 9'd1;
            end

            if (state == REQUEST) begin
                pf_count    <= '0;
                pf_inflight <= 1'b0;
            end else begin
                pf_inflight <= pf_issue;
                case ({pf_inflight, pf_pop})
                    2'b10: begin
                        if (pf_count == 2'd0) pf_data[0] <= memReadData;
                        else pf_data[1] <= memReadData;
                        pf_count <= pf_count + 2'd1;
                    end
                    2'b01: begin
                        pf_data[0] <= pf_data[1];
                        pf_count   <= pf_count - 2'd1;
                    end
                    2'b11: if (pf_count != 2'd0) pf_data[0] <= memReadData;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy                = (state == REQUEST) || (state == INIT) || (state == READ_DATA) ||
                              (state == WRITE_DATA) || (state == END_WRITE);
        done                = (state == FINISH);
        error               = error_q;
        memAddress          = mem_addr;
        memWriteEnable      = mem_we;
        memWriteData        = mem_we ? addressDataIn : '0;
        requestTransaction  = busy;
        beginTransactionOut = (state == INIT);
        burstSizeOut        = (state == INIT) ? 8'(burst_words - CW'(1)) : '0;
        readNotWriteOut     = (state == INIT) && dir;
        dataValidOut        = (state == WRITE_DATA) && pf_avail;
        endTransactionOut   = (state == END_WRITE);
        addressDataOut      = '0;
        if (state == INIT) addressDataOut = bus_addr;
        else if (dataValidOut) addressDataOut = pf_head;
    end

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: SSRAM model, scripted bus slave, and scoreboards
// for SSRAM writes (bus->SSRAM) and bus write words (SSRAM->bus).
module tb_dma_burst_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        readNotWrite = 1'b0;
    logic [31:0] busStartAddress = '0;
    logic [8:0]  memStartAddress = '0;
    logic [9:0]  blockSize = '0;
    logic [7:0]  burstSize = '0;
    logic        busy, done, error;
    logic [8:0]  memAddress;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        requestTransaction;
    logic        transactionGranted = 1'b0;
    logic        beginTransactionOut;
    logic [31:0] addressDataOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, dataValidOut, endTransactionOut;
    logic [31:0] addressDataIn = '0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        busErrorIn = 1'b0;
    logic        busyIn = 1'b0;

    always #5 clock = ~clock;

    dma_burst_engine dut (
        .clock(clock), .reset(reset), .start(start), .readNotWrite(readNotWrite),
        .busStartAddress(busStartAddress), .memStartAddress(memStartAddress),
        .blockSize(blockSize), .burstSize(burstSize),
        .busy(busy), .done(done), .error(error),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memWriteData(memWriteData), .memReadData(memReadData),
        .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
        .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
        .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
        .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn), .busyIn(busyIn)
    );

    // SSRAM port B model with a bench-side preload path.
    logic [31:0] ssram [512];
    logic        tb_we = 1'b0;
    logic [8:0]  tb_addr = '0;
    logic [31:0] tb_data = '0;

    always @(posedge clock) begin
        if (tb_we) ssram[tb_addr] <= tb_data;
        else if (memWriteEnable) ssram[memAddress] <= memWriteData;
        memReadData <= ssram[memAddress];
    end

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } mem_wr_t;

    mem_wr_t     sb_mem [$];
    logic [31:0] sb_bus [$];
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          exp_done = 0;
    logic [8:0]  exp_mem = '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    always @(negedge clock) begin : mon_mem
        mem_wr_t e;
        if (memWriteEnable) begin
            check("mem_wr_pending", 32'(sb_mem.size() != 0), 32'd1);
            if (sb_mem.size() != 0) begin
                e = sb_mem.pop_front();
                check("mem_wr_addr", 32'(memAddress), 32'(e.addr));
                check("mem_wr_data", memWriteData, e.data);
            end
        end
    end

    always @(negedge clock) begin : mon_bus
        logic [31:0] w;
        if (dataValidOut && !busyIn) begin
            check("bus_wr_pending", 32'(sb_bus.size() != 0), 32'd1);
            if (sb_bus.size() != 0) begin
                w = sb_bus.pop_front();
                check("bus_wr_data", addressDataOut, w);
            end
        end
        if (done) done_seen++;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic dir, input logic [31:0] ba, input logic [8:0] ma,
                            input logic [9:0] bs, input logic [7:0] bz);
        readNotWrite    = dir;
        busStartAddress = ba;
        memStartAddress = ma;
        blockSize       = bs;
        burstSize       = bz;
        exp_mem         = ma;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic preload(input logic [8:0] addr, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            tb_we   = 1'b1;
            tb_addr = addr + 9'(i);
            tb_data = base + 32'(i);
            sb_bus.push_back(base + 32'(i));
            cyc();
        end
        tb_we = 1'b0;
    endtask

    task automatic grant_burst(input logic [31:0] ea, input logic [7:0] ebz, input logic edir);
        int k = 0;
        while (!requestTransaction && k < 50) begin
            cyc();
            k++;
        end
        check("req_seen", 32'(requestTransaction), 32'd1);
        transactionGranted = 1'b1;
        cyc();
        transactionGranted = 1'b0;
        check("begin", 32'(beginTransactionOut), 32'd1);
        check("begin_addr", addressDataOut, ea);
        check("begin_bsz", 32'(burstSizeOut), 32'(ebz));
        check("begin_dir", 32'(readNotWriteOut), 32'(edir));
        cyc();
    endtask

    task automatic read_words(input int n, input logic [31:0] base, input logic send_end);
        for (int i = 0; i < n; i++) begin
            dataValidIn      = 1'b1;
            addressDataIn    = base + 32'(i);
            endTransactionIn = send_end && (i == n - 1);
            sb_mem.push_back('{addr: exp_mem, data: base + 32'(i)});
            exp_mem = exp_mem + 9'd1;
            cyc();
        end
        dataValidIn      = 1'b0;
        endTransactionIn = 1'b0;
        addressDataIn    = '0;
    endtask

    task automatic write_words(input int n, input int stall_at, input int stall_len);
        int          got = 0;
        int          k = 0;
        int          stall = stall_len;
        logic [31:0] held = '0;
        while (got < n && k < 100) begin
            if (got == stall_at && stall > 0) begin
                if (stall == stall_len) held = addressDataOut;
                else check("stall_hold", addressDataOut, held);
                check("stall_valid", 32'(dataValidOut), 32'd1);
                busyIn = 1'b1;
                stall--;
            end else begin
                busyIn = 1'b0;
                if (dataValidOut) got++;
            end
            cyc();
            k++;
        end
        busyIn = 1'b0;
        check("wr_word_count", 32'(got), 32'(n));
        check("end_wr", 32'(endTransactionOut), 32'd1);
    endtask

    task automatic expect_finish(input logic exp_err);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("error_at_done", 32'(error), 32'(exp_err));
        exp_done++;
        cyc();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        cyc();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_req", 32'(requestTransaction), 32'd0);
        check("rst_memaddr", 32'(memAddress), 32'd0);
        check("rst_addrdata", addressDataOut, 32'd0);
        reset = 1'b0;
        cyc();

        // Read 8 words in two bursts of 4.
        do_start(1'b1, 32'h100, 9'h010, 10'd8, 8'd3);
        check("busy_after_start", 32'(busy), 32'd1);
        grant_burst(32'h100, 8'd3, 1'b1);
        read_words(4, 32'hA000, 1'b1);
        grant_burst(32'h110, 8'd3, 1'b1);
        read_words(4, 32'hA004, 1'b1);
        expect_finish(1'b0);
        check("ssram_10", ssram[9'h010], 32'hA000);
        check("ssram_17", ssram[9'h017], 32'hA007);

        // Write 5 words: bursts of 4 then 1.
        preload(9'h040, 5, 32'hB000);
        do_start(1'b0, 32'h2000, 9'h040, 10'd5, 8'd3);
        grant_burst(32'h2000, 8'd3, 1'b0);
        write_words(4, -1, 0);
        cyc();
        grant_burst(32'h2010, 8'd0, 1'b0);
        write_words(1, -1, 0);
        cyc();
        expect_finish(1'b0);

        // Write 6 words in one burst with a 3-cycle slave stall on the third word.
        preload(9'h060, 6, 32'hC000);
        do_start(1'b0, 32'h3000, 9'h060, 10'd6, 8'd7);
        grant_burst(32'h3000, 8'd5, 1'b0);
        write_words(6, 2, 3);
        cyc();
        expect_finish(1'b0);

        // SSRAM address wrap.
        do_start(1'b1, 32'h400, 9'h1FE, 10'd4, 8'd7);
        grant_burst(32'h400, 8'd3, 1'b1);
        read_words(4, 32'hD000, 1'b1);
        expect_finish(1'b0);
        check("ssram_1ff", ssram[9'h1FF], 32'hD001);
        check("ssram_001", ssram[9'h001], 32'hD003);

        // Bus error during the second burst, then a fresh start clears the flag.
        do_start(1'b1, 32'h800, 9'h080, 10'd8, 8'd3);
        grant_burst(32'h800, 8'd3, 1'b1);
        read_words(4, 32'hE000, 1'b1);
        grant_burst(32'h810, 8'd3, 1'b1);
        read_words(1, 32'hE004, 1'b0);
        busErrorIn = 1'b1;
        cyc();
        busErrorIn = 1'b0;
        check("err_req_dropped", 32'(requestTransaction), 32'd0);
        expect_finish(1'b1);
        check("err_sticky", 32'(error), 32'd1);
        check("ssram_err_kept", ssram[9'h084], 32'hE004);
        do_start(1'b1, 32'h900, 9'h090, 10'd2, 8'd1);
        check("err_cleared", 32'(error), 32'd0);
        grant_burst(32'h900, 8'd1, 1'b1);
        read_words(2, 32'hF000, 1'b1);
        expect_finish(1'b0);

        // Reset in the middle of a read burst.
        do_start(1'b1, 32'hA00, 9'h0A0, 10'd4, 8'd3);
        grant_burst(32'hA00, 8'd3, 1'b1);
        read_words(1, 32'h1234, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'(requestTransaction), 32'd0);
        check("mid_rst_memaddr", 32'(memAddress), 32'd0);
        check("mid_rst_we", 32'(memWriteEnable), 32'd0);
        check("mid_rst_bus", {addressDataOut[31:3], beginTransactionOut, dataValidOut, endTransactionOut}, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        cyc();
        cyc();

        // Zero-length block: done only.
        do_start(1'b1, 32'hB00, 9'h0B0, 10'd0, 8'd3);
        check("zero_req", 32'(requestTransaction), 32'd0);
        expect_finish(1'b0);
        check("zero_busy_after", 32'(busy), 32'd0);
        cyc();

        check("done_pulse_count", 32'(done_seen), 32'(exp_done));
        check("sb_mem_drained", 32'(sb_mem.size()), 32'd0);
        check("sb_bus_drained", 32'(sb_bus.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
